sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port (read/write/addr/data/finished/refresh) among NUM_REQ requesters: mix core, recorder, player.
- Round-robin grant, one transaction at a time.
- Latches the granted request and holds it toward SDRAM until finished. Returns the result to the owner with a one-cycle finished pulse.
- Inserts a one-cycle refresh pulse whenever port ownership changes, and aborts hung transactions with a watchdog.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); requester 0 is the mix core.
- TIMEOUT, 1023, max BUSY cycles before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-low reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request.
- req_addr  in  23*NUM_REQ  packed per-requester address; slice k = [23k+22:23k].
- req_writedata  in  16*NUM_REQ  packed per-requester write data.
- req_finished  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_error  out  1  valid with req_finished; 1 = transaction aborted by watchdog.
- req_readdata  out  16  read result, valid with req_finished; shared by all requesters.
- sdram_read  out  1  read command to SDRAM controller.
- sdram_write  out  1  write command to SDRAM controller.
- sdram_addr  out  23  registered address.
- sdram_writedata  out  16  registered write data.
- sdram_readdata  in  16  data from SDRAM controller.
- sdram_finished  in  1  transaction done from SDRAM controller.
- sdram_refresh  out  1  one-cycle refresh pulse on ownership change.
- grant_id  out  3  current/last owner index, for debug.

Behaviour:
- Reset (i_rst=0 at posedge): state IDLE; every output is 0; last_owner = NUM_REQ-1; owner_valid = 0. Reset mid-transaction drops the command immediately, with no finished pulse.
- States: IDLE, REFRESH, BUSY, DONE.
- IDLE:
  - Requester k is pending if req_read[k] or req_write[k].
  - Pick the first pending index searching last_owner+1, +2, … modulo NUM_REQ.
  - Latch its addr, writedata and op. op = write if req_write is set, else read; write wins if both are asserted.
  - Set grant_id and last_owner.
  - Next state is REFRESH if owner_valid=0 or the winner differs from the previous owner; otherwise BUSY.
  - No pending request: stay in IDLE.
- REFRESH: exactly 1 cycle. sdram_refresh=1, sdram_read=sdram_write=0. Sets owner_valid=1. Goes to BUSY.
- BUSY:
  - sdram_read or sdram_write (per latched op) held at 1.
  - sdram_addr and sdram_writedata driven from registers, stable for the whole state.
  - Requester inputs are ignored here; they may change without effect.
  - On sdram_finished=1 sampled: capture sdram_readdata into req_readdata, deassert the command, go to DONE.
  - Watchdog counter counts BUSY cycles. If it reaches TIMEOUT (TIMEOUT≠0) with no finished: deassert the command, set req_error=1, req_readdata=0, clear owner_valid so the next grant refreshes, go to DONE.
  - finished and timeout in the same cycle: finished wins, error=0.
- DONE: exactly 1 cycle.
  - req_finished[owner]=1; req_error/req_readdata valid; SDRAM commands 0.
  - Requests are not sampled.
  - Goes to IDLE.
  - req_error and req_readdata hold until the next DONE.
- Requester contract: hold the request (op, addr, data) asserted until its req_finished pulse; deassert on the following cycle (the IDLE cycle). A request still asserted in that IDLE cycle is treated as a new transaction.
- Minimum latencies, request sampled in IDLE at cycle t:
  - Same owner: command at t+1, finished pulse at (cycle finished is sampled)+1.
  - Owner change: refresh at t+1, command at t+2.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,… Each ownership change costs one REFRESH cycle.
- sdram_refresh, req_finished and the SDRAM commands are never asserted together.

Test Plan:
- Reset then single read by req1 at addr 0x00_1234, SDRAM returns 0xBEEF after 3 cycles -> refresh pulse at t+1, sdram_read t+2..finish, req_finished=3'b010 with req_readdata=0xBEEF, error=0.
- Two back-to-back writes from req0 (0x10→0xAAAA, 0x11→0x5555) -> refresh only before the first write; second write's command one cycle after the IDLE following DONE; addr/data stable through BUSY.
- All three requesters asserted continuously -> grant order 0,1,2,0,1,2 with a refresh before each; no requester served twice in a row.
- req2 asserts read and write together, addr 0x7F_FFFF -> sdram_write=1, sdram_read=0, sdram_addr=0x7F_FFFF.
- TIMEOUT=8, sdram_finished never rises -> command drops after 8 BUSY cycles, req_finished pulses with req_error=1 and req_readdata=0; next grant, same owner, still gets a refresh pulse.
- i_rst=0 mid-BUSY -> next cycle all outputs 0, no req_finished; after release a request from req0 produces a refresh first.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester and SDRAM-side signal bundle for sdram_port_arbiter
interface sdram_port_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    req_read;
   logic [NUM_REQ-1:0]    req_write;
   logic [23*NUM_REQ-1:0] req_addr;
   logic [16*NUM_REQ-1:0] req_writedata;
   logic [NUM_REQ-1:0]    req_finished;
   logic                  req_error;
   logic [15:0]           req_readdata;
   logic                  sdram_read;
   logic                  sdram_write;
   logic [22:0]           sdram_addr;
   logic [15:0]           sdram_writedata;
   logic [15:0]           sdram_readdata;
   logic                  sdram_finished;
   logic                  sdram_refresh;
   logic [2:0]            grant_id;

   // arbiter side
   modport slave (
      input  req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
      output req_finished, req_error, req_readdata, sdram_read, sdram_write, sdram_addr,
             sdram_writedata, sdram_refresh, grant_id
   );

   // requesters plus SDRAM controller side
   modport master (
      output req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
      input  req_finished, req_error, req_readdata, sdram_read, sdram_write, sdram_addr,
             sdram_writedata, sdram_refresh, grant_id
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM controller port
module sdram_port_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic                i_clk,
   input  logic                i_rst,
   sdram_port_arbiter_if.slave bus
);
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFRESH,
      S_BUSY,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [2:0]        r_last_owner;
   logic [2:0]        r_grant;
   logic              r_owner_valid;
   logic              r_op_write;
   logic [22:0]       r_addr;
   logic [15:0]       r_wdata;
   logic [15:0]       r_readdata;
   logic              r_error;
   logic [WD_W-1:0]   r_wd;

   logic [NUM_REQ-1:0] w_pending;
   logic               w_found;
   logic [2:0]         w_winner;
   logic [22:0]        w_sel_addr;
   logic [15:0]        w_sel_wdata;
   logic               w_sel_write;
   logic               w_timeout;
   logic               w_change;

   assign w_pending = bus.req_read | bus.req_write;
   assign w_change  = !r_owner_valid || (w_winner != r_last_owner);
   assign w_timeout = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT - 1)) && !bus.sdram_finished;

   // Round-robin search: first pending requester after the last owner, wrapping
   always_comb begin : rr_search
      logic [3:0] v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         v_idx = {1'b0, r_last_owner} + 4'(i);
         if (v_idx >= 4'(NUM_REQ)) begin
            v_idx = v_idx - 4'(NUM_REQ);
         end
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (v_idx == 4'(j)) && w_pending[j]) begin
               w_found  = 1'b1;
               w_winner = 3'(j);
            end
         end
      end
   end

   // Select the winner's address, data and operation (write wins over read)
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_write = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_winner == 3'(k)) begin
            w_sel_addr  = bus.req_addr[23*k +: 23];
            w_sel_wdata = bus.req_writedata[16*k +: 16];
            w_sel_write = bus.req_write[k];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; ownership change forces one refresh cycle before the command
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_next_state = w_change ? S_REFRESH : S_BUSY;
            end
         end
         S_REFRESH: w_next_state = S_BUSY;
         S_BUSY: begin
            if (bus.sdram_finished || w_timeout) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Grant latching, result capture, ownership tracking and BUSY watchdog
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_last_owner  <= 3'(NUM_REQ - 1);
         r_grant       <= '0;
         r_owner_valid <= 1'b0;
         r_op_write    <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_readdata    <= '0;
         r_error       <= 1'b0;
         r_wd          <= '0;
      end else begin
         r_wd <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_addr       <= w_sel_addr;
                  r_wdata      <= w_sel_wdata;
                  r_op_write   <= w_sel_write;
                  r_grant      <= w_winner;
                  r_last_owner <= w_winner;
               end
            end
            S_REFRESH: r_owner_valid <= 1'b1;
            S_BUSY: begin
               if (bus.sdram_finished) begin
                  r_readdata <= bus.sdram_readdata;
                  r_error    <= 1'b0;
               end else if (w_timeout) begin
                  r_readdata    <= '0;
                  r_error       <= 1'b1;
                  r_owner_valid <= 1'b0;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // One-hot completion pulse toward the current owner during DONE
   always_comb begin
      bus.req_finished = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         bus.req_finished[k] = (r_state == S_DONE) && (r_grant == 3'(k));
      end
   end

   assign bus.sdram_read      = (r_state == S_BUSY) && !r_op_write;
   assign bus.sdram_write     = (r_state == S_BUSY) && r_op_write;
   assign bus.sdram_refresh   = (r_state == S_REFRESH);
   assign bus.sdram_addr      = r_addr;
   assign bus.sdram_writedata = r_wdata;
   assign bus.req_readdata    = r_readdata;
   assign bus.req_error       = r_error;
   assign bus.grant_id        = r_grant;
endmodule
